// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount unary frame generator.
package popcount_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Bits needed to hold a count in 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_unary_sel.sv
// Frame bit selector: thermometer order by default, evenly spread ones when
// POPCOUNT_UNARY_SPREAD_EN is defined.
module popcount_unary_sel
  import popcount_pkg::*;
#(
  parameter int unsigned  WIDTH = 4,
  localparam int unsigned CNT_W = cnt_width(WIDTH),
  localparam int unsigned ACC_W = CNT_W + 1
) (
`ifdef POPCOUNT_UNARY_SPREAD_EN
  input  logic [ACC_W-1:0] acc,
  input  logic [CNT_W-1:0] cnt,
  output logic             bit_c,
  output logic [ACC_W-1:0] acc_nxt_c
`else
  input  logic [$clog2(WIDTH)-1:0] idx,
  input  logic [CNT_W-1:0]         cnt,
  output logic                     bit_c
`endif
);

`ifdef POPCOUNT_UNARY_SPREAD_EN
  logic [ACC_W-1:0] sum;

  // Bresenham-style accumulator: a one is emitted each time the sum wraps WIDTH.
  always_comb begin
    sum       = acc + ACC_W'(cnt);
    bit_c     = 1'b0;
    acc_nxt_c = sum;
    if (sum >= ACC_W'(WIDTH)) begin
      bit_c     = 1'b1;
      acc_nxt_c = sum - ACC_W'(WIDTH);
    end
  end
`else
  always_comb begin
    bit_c = (CNT_W'(idx) < cnt);
  end
`endif

endmodule

// File: rtl/popcount_unary_gen.sv
// Count-to-unary serial frame generator with valid/ready on both sides.
// Optional macro POPCOUNT_UNARY_SPREAD_EN spreads the ones evenly across the frame.
module popcount_unary_gen
  import popcount_pkg::*;
#(
  parameter int unsigned  WIDTH = 4,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic             out_sat
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             emit, last, xfer, accept, sel_bit;
`ifdef POPCOUNT_UNARY_SPREAD_EN
  logic [CNT_W:0]   acc_q, acc_d, acc_nxt;
`endif

  // Handshake decode; in_ready may rise on the final bit so frames chain without a bubble.
  always_comb begin
    emit   = (state_q == EMIT);
    last   = emit && (idx_q == IDX_W'(WIDTH - 1));
    xfer   = emit && out_ready;
    accept = in_valid && (!emit || (last && out_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: if (xfer && last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
`ifdef POPCOUNT_UNARY_SPREAD_EN
      acc_q <= '0;
`endif
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
`ifdef POPCOUNT_UNARY_SPREAD_EN
      acc_q <= acc_d;
`endif
    end
  end

  // Count is clipped and latched only at accept; index advances per transfer.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
`ifdef POPCOUNT_UNARY_SPREAD_EN
    acc_d = acc_q;
    if (xfer) acc_d = acc_nxt;
`endif
    if (xfer) begin
      idx_d = last ? '0 : idx_q + IDX_W'(1);
      if (last) sat_d = 1'b0;
    end
    if (accept) begin
      idx_d = '0;
      sat_d = (in_count > CNT_W'(WIDTH));
      cnt_d = sat_d ? CNT_W'(WIDTH) : in_count;
`ifdef POPCOUNT_UNARY_SPREAD_EN
      acc_d = '0;
`endif
    end
  end

  popcount_unary_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
`ifdef POPCOUNT_UNARY_SPREAD_EN
    .acc       (acc_q),
    .cnt       (cnt_q),
    .bit_c     (sel_bit),
    .acc_nxt_c (acc_nxt)
`else
    .idx       (idx_q),
    .cnt       (cnt_q),
    .bit_c     (sel_bit)
`endif
  );

  always_comb begin
    in_ready  = !emit || (last && out_ready);
    out_valid = emit;
    out_bit   = emit && sel_bit;
    out_last  = last;
    out_sat   = emit && sat_q;
  end

endmodule

// File: tb/tb_popcount_unary_gen.sv
// Directed bench for popcount_unary_gen at WIDTH=4; honours POPCOUNT_UNARY_SPREAD_EN.
module tb_popcount_unary_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_count;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       out_ready;
  logic       out_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  popcount_unary_gen #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  // Expected frames, leftmost bit emitted first.
`ifdef POPCOUNT_UNARY_SPREAD_EN
  localparam logic [3:0] F0 = 4'b0000, F1 = 4'b0001, F2 = 4'b0101, F3 = 4'b0111, F4 = 4'b1111;
`else
  localparam logic [3:0] F0 = 4'b0000, F1 = 4'b1000, F2 = 4'b1100, F3 = 4'b1110, F4 = 4'b1111;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a count while idle and let it be accepted on the next edge.
  task automatic start(input logic [2:0] cnt);
    in_valid = 1'b1;
    in_count = cnt;
    #1;
    check("start_in_ready", 32'(in_ready), 32'd1);
    step();
  endtask

  // Drain one frame; after the first cycle the input side is set to nv/nc.
  task automatic collect(input string tag, input logic [3:0] exp_bits, input logic exp_sat,
                         input bit stall, input logic nv, input logic [2:0] nc);
    int k = 0;
    int cyc = 0;
    logic [3:0] bits = exp_bits;
    while (k < 4 && cyc < 20) begin
      out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
      if (cyc == 0) begin
        in_valid = nv;
        in_count = nc;
      end
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bit"},   32'(out_bit),   32'(bits[3-k]));
      check({tag, "_last"},  32'(out_last),  32'(k == 3));
      check({tag, "_sat"},   32'(out_sat),   32'(exp_sat));
      check({tag, "_ready"}, 32'(in_ready),  32'(k == 3 && out_ready));
      if (out_ready) k++;
      cyc++;
      step();
    end
    check({tag, "_xfers"}, 32'(k), 32'd4);
    out_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_bit"},   32'(out_bit),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    step(); step();
    check_idle("reset");
    check("reset_sat", 32'(out_sat), 32'd0);
    rst = 1'b0;
    step();

    // Count 3 with continuous ready.
    start(3'd3);
    collect("c3", F3, 1'b0, 1'b0, 1'b0, 3'd0);
    check_idle("c3_end");

    // Back-to-back 0 then 4 with in_valid held: no bubble between frames.
    start(3'd0);
    collect("b2b0", F0, 1'b0, 1'b0, 1'b1, 3'd4);
    collect("b2b4", F4, 1'b0, 1'b0, 1'b0, 3'd0);
    check_idle("b2b_end");

    // Over-range count saturates.
    start(3'd7);
    collect("sat7", F4, 1'b1, 1'b0, 1'b0, 3'd0);
    check_idle("sat_end");

    // Count 2 with out_ready toggling; bits hold while stalled.
    start(3'd2);
    collect("stall2", F2, 1'b0, 1'b1, 1'b0, 3'd0);
    check_idle("stall_end");

    // Reset on the second bit of a count-3 frame drops the frame.
    start(3'd3);
    in_valid = 1'b0;
    #1;
    check("rstmid_b1", 32'(out_bit), 32'(F3[3]));
    step();
    rst = 1'b1;
    #1;
    check("rstmid_b2", 32'(out_bit), 32'(F3[2]));
    check("rstmid_v2", 32'(out_valid), 32'd1);
    step();
    check_idle("rstmid_after");
    rst = 1'b0;
    step();
    start(3'd1);
    collect("c1", F1, 1'b0, 1'b0, 1'b0, 3'd0);
    check_idle("c1_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/popcount_unary_gen.md
Name: popcount_unary_gen

Overview:
- Inverse of the popcount blocks: takes a count value and transmits a WIDTH-bit frame, serially, containing exactly that many ones.
- Serves as the stimulus/transmit end for popcount-based ternary neuron datapaths, e.g. replaying activations into a popcount tree.
- One frame per accepted count, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 4, frame length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), count width; default 3 when WIDTH=4. Derived, never overridden.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_count is valid.
- in_count  input  CNT_W  number of ones to emit.
- in_ready  output  1  block can accept a count this cycle.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  current frame bit.
- out_last  output  1  high on the final (WIDTH-th) bit of a frame.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_sat  output  1  current frame's count was clipped to WIDTH.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_last=0, out_sat=0; internal index and count registers are 0.
- Reset mid-frame drops the frame with no partial completion. out_valid is 0 from the next cycle.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1.
- Input accept: in_valid & in_ready. On accept:
  - latch cnt = min(in_count, WIDTH).
  - out_sat = (in_count > WIDTH).
  - idx = 0, go to EMIT. The first bit is valid the next cycle (latency 1).
- EMIT:
  - out_bit = sel(idx, cnt).
  - out_last = (idx == WIDTH-1).
  - Transfer occurs when out_ready=1; then idx++.
  - With out_ready=0, out_bit, out_last and idx hold.
- Frame end: a transfer with out_last=1 ends the frame.
  - If in_valid is also high that cycle, the new count is accepted and the next frame starts with no bubble. For this, in_ready = IDLE | (EMIT & out_last & out_ready), combinational from out_ready.
  - Otherwise go to IDLE.
- Default sel (thermometer): bit = (idx < cnt), i.e. ones first.
- Invariants:
  - Every frame has exactly WIDTH transfers.
  - Ones in a frame = min(in_count, WIDTH).
  - count 0 gives all zeros; count WIDTH gives all ones.
- in_count is sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: POPCOUNT_UNARY_SPREAD_EN.
- Defined: ones are spread evenly using an accumulator acc (CNT_W+1 bits, reset 0 at each accept).
  - Each transfer computes s = acc + cnt.
  - If s >= WIDTH: bit=1, acc = s - WIDTH.
  - Else: bit=0, acc = s.
  - The bit is computed combinationally from the pre-transfer acc. The number of ones is still exactly cnt.
- Undefined: thermometer ordering; no acc register.

Decomposition:
- Package popcount_pkg:
  - state enum {IDLE, EMIT}.
  - cnt_width(WIDTH) function.
- Sub-module popcount_unary_sel: combinational bit selector (idx/acc, cnt -> bit, next acc). Isolates the macro-dependent logic.
- Top level holds the FSM, counters and handshake.

Test Plan (WIDTH=4):
- Reset, then in_count=3 with out_ready=1 -> bits 1,1,1,0 on cycles 1..4; out_last on cycle 4; in_ready=0 during cycles 1..3.
- Back-to-back counts 0 then 4, in_valid held, out_ready=1 -> bits 0000 then 1111 with no idle cycle; out_last every 4th bit.
- in_count=7 -> bits 1111, out_sat=1 for the whole frame.
- in_count=2, out_ready toggling 1,0,1,0… -> bits 1,1,0,0 each held while stalled; exactly 4 transfers.
- rst asserted on bit 2 of a count=3 frame -> out_valid=0 next cycle; a fresh count=1 then gives 1,0,0,0.
- With POPCOUNT_UNARY_SPREAD_EN, in_count=2 -> bits 0,1,0,1; in_count=3 -> 0,1,1,1; ones always equal the count.
